// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch sequencing controller.
// Holds state encoding, digit scan indices and field-select values.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_ADJ   = 2'd2
    } state_t;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD counter 00..MAX with wrap to 00.
// Ports: clk, rst (sync, high), inc, carry_en -> tens, ones, carry_out.
module bcd_pair_cnt #(
    parameter int unsigned MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       carry_en,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MAX % 10);

    logic w_at_max;

    assign w_at_max  = (tens == MAX_T) && (ones == MAX_O);
    // Carry only on the wrapping increment, and only when enabled.
    assign carry_out = inc && carry_en && w_at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (w_at_max) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: divider levels -> ticks, MM:SS run/pause/adjust,
// 4-digit scan with blink. Ports: clk_in, rst, clk_1/2/f/b, pause_p, adj,
// sel in; BCD count, running, digit_sel/val/blank out.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned MIN_MAX  = 59,
    parameter bit          ADJ_FAST = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_1,
    input  logic       clk_2,
    input  logic       clk_f,
    input  logic       clk_b,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [1:0] digit_sel,
    output logic [3:0] digit_val,
    output logic       digit_blank
);

    state_t     r_state, w_state_nx;
    logic       r_was_run, w_was_run_nx;
    logic       r_clk1_d, r_clk2_d, r_clkf_d;
    logic       w_tick_1, w_tick_2, w_tick_f, w_adj_tick;
    logic       w_run_inc, w_adj_inc;
    logic       w_sec_inc, w_min_inc, w_sec_carry, w_min_carry;
    logic [1:0] r_digit_sel;
    logic [3:0] r_digit_val, w_digit_val;
    logic       r_blank, w_blank, w_dig_is_min;

    assign w_tick_1 = clk_1 & ~r_clk1_d;
    assign w_tick_2 = clk_2 & ~r_clk2_d;
    assign w_tick_f = clk_f & ~r_clkf_d;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_clk1_d <= 1'b0;
            r_clk2_d <= 1'b0;
            r_clkf_d <= 1'b0;
        end else begin
            r_clk1_d <= clk_1;
            r_clk2_d <= clk_2;
            r_clkf_d <= clk_f;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_was_run <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_was_run <= w_was_run_nx;
        end
    end

    // adj dominates everything; was_run is only captured on ADJ entry.
    always_comb begin
        w_state_nx   = r_state;
        w_was_run_nx = r_was_run;
        if (adj) begin
            w_state_nx = ST_ADJ;
            if (r_state != ST_ADJ)
                w_was_run_nx = (r_state == ST_RUN);
        end else begin
            unique case (r_state)
                ST_RUN:   if (pause_p) w_state_nx = ST_PAUSE;
                ST_PAUSE: if (pause_p) w_state_nx = ST_RUN;
                ST_ADJ:   w_state_nx = r_was_run ? ST_RUN : ST_PAUSE;
                default:  w_state_nx = ST_RUN;
            endcase
        end
    end

    // A run tick is dropped when the state is changing that cycle.
    assign w_run_inc  = (r_state == ST_RUN) && !adj && !pause_p
                        && w_tick_1;
    assign w_adj_tick = ADJ_FAST ? w_tick_2 : w_tick_1;
    assign w_adj_inc  = (r_state == ST_ADJ) && adj && w_adj_tick;

    assign w_sec_inc = w_run_inc | (w_adj_inc && sel == SEL_SEC);
    assign w_min_inc = w_sec_carry | (w_adj_inc && sel == SEL_MIN);

    bcd_pair_cnt #(.MAX(59)) u_sec (
        .clk       (clk_in),
        .rst       (rst),
        .inc       (w_sec_inc),
        .carry_en  (w_run_inc),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (w_sec_carry)
    );

    bcd_pair_cnt #(.MAX(MIN_MAX)) u_min (
        .clk       (clk_in),
        .rst       (rst),
        .inc       (w_min_inc),
        .carry_en  (1'b0),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (w_min_carry)
    );

    always_comb begin
        w_digit_val = 4'd0;
        unique case (r_digit_sel)
            DIG_SEC_ONES: w_digit_val = sec_ones;
            DIG_SEC_TENS: w_digit_val = sec_tens;
            DIG_MIN_ONES: w_digit_val = min_ones;
            DIG_MIN_TENS: w_digit_val = min_tens;
            default:      w_digit_val = 4'd0;
        endcase
    end

    assign w_dig_is_min = (r_digit_sel == DIG_MIN_ONES)
                       || (r_digit_sel == DIG_MIN_TENS);
    assign w_blank = (r_state == ST_ADJ) && clk_b
                  && (w_dig_is_min == (sel == SEL_MIN));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_digit_sel <= DIG_SEC_ONES;
            r_digit_val <= 4'd0;
            r_blank     <= 1'b0;
        end else begin
            if (w_tick_f)
                r_digit_sel <= r_digit_sel + 2'd1;
            r_digit_val <= w_digit_val;
            r_blank     <= w_blank;
        end
    end

    assign running     = (r_state == ST_RUN);
    assign digit_sel   = r_digit_sel;
    assign digit_val   = r_digit_val;
    assign digit_blank = r_blank;

    logic w_unused;
    assign w_unused = w_min_carry;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl.
// Drives divider levels and controls; checks count, state and scan.
module tb_stopwatch_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1 = 1'b0, clk_2 = 1'b0;
    logic       clk_f = 1'b0, clk_b = 1'b0;
    logic       pause_p = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, digit_blank;
    logic [1:0] digit_sel;
    logic [3:0] digit_val;

    int n_chk = 0;
    int n_fail = 0;
    int m = 0;
    int s = 0;
    logic [15:0] q_exp[$];
    logic [15:0] w_cnt;

    assign w_cnt = {min_tens, min_ones, sec_tens, sec_ones};

    stopwatch_ctrl #(.MIN_MAX(59), .ADJ_FAST(1'b1)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .clk_1       (clk_1),
        .clk_2       (clk_2),
        .clk_f       (clk_f),
        .clk_b       (clk_b),
        .pause_p     (pause_p),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .digit_sel   (digit_sel),
        .digit_val   (digit_val),
        .digit_blank (digit_blank)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse1(input bit do_inc);
        logic [15:0] old;
        old = bcd(m, s);
        clk_1 = 1'b1;
        if (do_inc) begin
            s++;
            if (s == 60) begin
                s = 0;
                m = (m + 1) % 60;
            end
        end
        q_exp.push_back(bcd(m, s));
        chk("pre_tick", w_cnt, old);
        cyc();
        chk("run_cnt", w_cnt, q_exp.pop_front());
        clk_1 = 1'b0;
        cyc();
    endtask

    task automatic pulse2(input logic fsel);
        clk_2 = 1'b1;
        if (fsel) s = (s + 1) % 60;
        else      m = (m + 1) % 60;
        q_exp.push_back(bcd(m, s));
        cyc();
        chk("adj_cnt", w_cnt, q_exp.pop_front());
        clk_2 = 1'b0;
        cyc();
    endtask

    task automatic pause_pulse();
        pause_p = 1'b1;
        cyc();
        pause_p = 1'b0;
    endtask

    initial begin
        logic [3:0] vals [5];
        vals[0] = 4'd3; vals[1] = 4'd2; vals[2] = 4'd1;
        vals[3] = 4'd4; vals[4] = 4'd3;

        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_cnt", w_cnt, 16'h0000);
        chk("rst_run", running, 1);
        chk("rst_dsel", digit_sel, 0);
        chk("rst_dval", digit_val, 0);
        chk("rst_blank", digit_blank, 0);

        for (int i = 0; i < 60; i++) pulse1(1'b1);
        chk("one_min", w_cnt, 16'h0100);
        chk("one_min_run", running, 1);

        adj = 1'b1;
        sel = 1'b0;
        cyc();
        for (int i = 0; i < 58; i++) pulse2(1'b0);
        sel = 1'b1;
        for (int i = 0; i < 58; i++) pulse2(1'b1);
        chk("preload", w_cnt, 16'h5958);
        adj = 1'b0;
        cyc();
        chk("adj_to_run", running, 1);
        pulse1(1'b1);
        pulse1(1'b1);
        chk("wrap_all", w_cnt, 16'h0000);

        clk_1 = 1'b1;
        pause_p = 1'b1;
        cyc();
        pause_p = 1'b0;
        clk_1 = 1'b0;
        chk("pause_tick_run", running, 0);
        chk("pause_tick_cnt", w_cnt, bcd(m, s));
        cyc();
        for (int i = 0; i < 5; i++) pulse1(1'b0);
        pause_pulse();
        chk("resume", running, 1);

        for (int i = 0; i < 58; i++) pulse1(1'b1);
        chk("at_0058", w_cnt, 16'h0058);
        pause_pulse();
        chk("paused", running, 0);
        adj = 1'b1;
        sel = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) pulse2(1'b1);
        chk("sec_nocarry", w_cnt, 16'h0001);
        adj = 1'b0;
        cyc();
        chk("adj_to_pause", running, 0);
        pulse1(1'b0);

        adj = 1'b1;
        sel = 1'b0;
        cyc();
        for (int i = 0; i < 12; i++) pulse2(1'b0);
        sel = 1'b1;
        for (int i = 0; i < 33; i++) pulse2(1'b1);
        adj = 1'b0;
        cyc();
        chk("at_1234", w_cnt, 16'h1234);
        for (int k = 0; k < 5; k++) begin
            clk_f = 1'b1;
            q_exp.push_back(16'(vals[k]));
            cyc();
            clk_f = 1'b0;
            chk("scan_sel", digit_sel, (k + 1) % 4);
            cyc();
            chk("scan_val", digit_val, q_exp.pop_front());
        end

        adj = 1'b1;
        sel = 1'b0;
        clk_b = 1'b1;
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            clk_f = 1'b1;
            cyc();
            clk_f = 1'b0;
            cyc();
            chk("blink_sel", digit_sel, (k + 2) % 4);
            chk("blink_on", digit_blank, ((k + 2) % 4) >= 2);
        end
        clk_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            clk_f = 1'b1;
            cyc();
            clk_f = 1'b0;
            cyc();
            chk("blink_off", digit_blank, 0);
        end

        rst = 1'b1;
        cyc();
        chk("mid_rst_cnt", w_cnt, 16'h0000);
        chk("mid_rst_run", running, 1);
        chk("mid_rst_dsel", digit_sel, 0);
        chk("mid_rst_blank", digit_blank, 0);
        rst = 1'b0;
        adj = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
